store_buffer: RTL and testbench

Write-back store buffer between the single-cycle RISC-V core's data port and a slow, handshaked data memory. It captures core stores in one cycle into a small in-order FIFO and drains them to memory in the background. Loads are served by store-to-load forwarding from the FIFO or by a stalled memory read. A `Stall` output freezes the core (PC and register-file writes) whenever a request cannot complete in the current cycle.

---
 rtl/store_buffer_if.sv | 19 +
 rtl/store_buffer.sv | 152 +++++++++++++++
 tb/tb_store_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Handshaked data-memory port between the store buffer (master) and memory (slave).
interface store_buffer_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/store_buffer.sv
// Write-back store buffer: in-order store FIFO drained to a slow memory in the
// background, with youngest-entry store-to-load forwarding and stalled read misses.
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MemWrite,
    input  logic           MemRead,
    input  logic [31:0]    DataAdr,
    input  logic [31:0]    WriteData,
    output logic [31:0]    ReadData,
    output logic           Stall,
    output logic           Empty,
    store_buffer_if.master mem
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned WORD_W = 30;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [31:0]       data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR    = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    entry_t            fifo [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [31:0]       rdata_q;

    logic              full;
    logic              hit;
    logic              load_miss;
    logic              enq;
    logic              pop;
    logic [31:0]       fwd_data;
    logic [WORD_W-1:0] adr_word;
    logic              unused_adr_bits;

    assign adr_word        = DataAdr[31:2];
    assign unused_adr_bits = ^DataAdr[1:0];

    assign full      = (count == CNT_W'(DEPTH));
    assign enq       = MemWrite & ~full;
    assign load_miss = MemRead & ~MemWrite & ~hit;
    assign pop       = (state == WR) & mem.mem_ack;

    // Scan oldest to youngest so the last match wins (youngest store forwards).
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count) && (fifo[head + PTR_W'(k)].word == adr_word)) begin
                hit      = 1'b1;
                fwd_data = fifo[head + PTR_W'(k)].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory-port drive; load misses take priority over draining.
    always_comb begin
        state_next    = state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (load_miss) begin
                    state_next = RD;
                end else if ((count != '0) || enq) begin
                    state_next = WR;
                end
            end
            WR: begin
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {fifo[head].word, 2'b00};
                mem.mem_wdata = fifo[head].data;
                if (mem.mem_ack) begin
                    state_next = IDLE;
                end
            end
            RD: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {adr_word, 2'b00};
                if (mem.mem_ack) begin
                    state_next = RDONE;
                end
            end
            RDONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rdata_q <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if ((state == RD) && mem.mem_ack) begin
                rdata_q <= mem.mem_rdata;
            end
        end
    end

    // Entry storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            fifo[tail] <= {adr_word, WriteData};
        end
    end

    assign Stall    = (MemWrite & full) | (load_miss & (state != RDONE));
    assign ReadData = (state == RDONE) ? rdata_q : (hit ? fwd_data : 32'd0);
    assign Empty    = (count == '0) & ((state == IDLE) | (state == RDONE));
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table, directed corner sequences,
// and random core traffic against an architectural-memory / FIFO-occupancy model.
module tb_store_buffer;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;

    store_buffer_if mem ();

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .DataAdr  (DataAdr),
        .WriteData(WriteData),
        .ReadData (ReadData),
        .Stall    (Stall),
        .Empty    (Empty),
        .mem      (mem)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_model [int];
    logic [31:0] arch      [int];
    bit          ack_en;
    int          mem_lat;

    typedef struct {
        logic [29:0] word;
        logic [31:0] data;
    } ent_t;
    ent_t q [$];

    typedef struct {
        bit          we;
        bit          rd;
        logic [31:0] adr;
        logic [31:0] wd;
        bit          stall;
        logic [31:0] rdata;
        bit          req;
        logic [31:0] addr;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input int w);
        return mem_model.exists(w) ? mem_model[w] : 32'd0;
    endfunction

    function automatic logic [31:0] rd_arch(input int w);
        return arch.exists(w) ? arch[w] : 32'd0;
    endfunction

    function automatic vec_t mk(input bit we, input bit rd, input int adr, input int wd,
                                input bit stall, input int rdata, input bit req, input int addr);
        vec_t v;
        v.we = we; v.rd = rd; v.adr = 32'(adr); v.wd = 32'(wd);
        v.stall = stall; v.rdata = 32'(rdata); v.req = req; v.addr = 32'(addr);
        return v;
    endfunction

    // Memory: acks after mem_lat extra request cycles; updates its contents on write acks.
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem.mem_ack   = 1'b0;
            mem.mem_rdata = '0;
            if (mem.mem_req && ack_en && !reset) begin
                if (wait_cnt >= mem_lat) begin
                    mem.mem_ack = 1'b1;
                    if (mem.mem_we) mem_model[int'(mem.mem_addr >> 2)] = mem.mem_wdata;
                    else            mem.mem_rdata = rd_mem(int'(mem.mem_addr >> 2));
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!mem.mem_req) begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        for (int c = 0; c < 60; c++) begin
            #4;
            if (Empty) break;
            @(negedge clk);
        end
        check(nm, 32'(Empty), 32'd1);
        @(negedge clk);
    endtask

    // Presents a load until Stall drops; checks RD address, data and stall length.
    task automatic run_load(input logic [31:0] adr, input logic [31:0] exp,
                            input int exp_stalls, input string nm);
        int stalls;
        bit saw_rd;
        bit done;
        stalls = 0; saw_rd = 1'b0; done = 1'b0;
        MemWrite = 1'b0; MemRead = 1'b1; DataAdr = adr;
        for (int c = 0; c < 30 && !done; c++) begin
            #4;
            if (!Stall) begin
                done = 1'b1;
                check({nm, "_rdata"}, ReadData, exp);
            end else begin
                stalls++;
                if (mem.mem_req && !mem.mem_we && !saw_rd) begin
                    saw_rd = 1'b1;
                    check({nm, "_rd_addr"}, mem.mem_addr, {adr[31:2], 2'b00});
                end
            end
            @(negedge clk);
        end
        MemRead = 1'b0;
        check({nm, "_completed"}, 32'(done), 32'd1);
        check({nm, "_rd_issued"}, 32'(saw_rd), 32'd1);
        check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    endtask

    initial begin
        reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; DataAdr = '0; WriteData = '0;
        ack_en = 1'b0; mem_lat = 0;

        // Reset state
        do_reset();
        #4;
        check("rst_mem_req",   32'(mem.mem_req), 32'd0);
        check("rst_mem_we",    32'(mem.mem_we),  32'd0);
        check("rst_mem_addr",  mem.mem_addr,     32'd0);
        check("rst_mem_wdata", mem.mem_wdata,    32'd0);
        check("rst_readdata",  ReadData,         32'd0);
        check("rst_empty",     32'(Empty),       32'd1);
        check("rst_stall",     32'(Stall),       32'd0);
        @(negedge clk);

        // Vector table, memory never acks: forwarding, youngest match, full FIFO, miss stall
        vecs[0]  = mk(0, 0,   0,  0, 0,  0, 0,  0);
        vecs[1]  = mk(1, 0,  96,  7, 0,  0, 0,  0);
        vecs[2]  = mk(1, 0,  96,  9, 0,  0, 1, 96);
        vecs[3]  = mk(0, 1,  96,  0, 0,  9, 1, 96);
        vecs[4]  = mk(0, 1,  97,  0, 0,  9, 1, 96);
        vecs[5]  = mk(1, 0, 100, 11, 0,  0, 1, 96);
        vecs[6]  = mk(1, 0, 104, 13, 0,  0, 1, 96);
        vecs[7]  = mk(1, 0, 108, 15, 1,  0, 1, 96);
        vecs[8]  = mk(0, 1, 101,  0, 0, 11, 1, 96);
        vecs[9]  = mk(0, 1, 200,  0, 1,  0, 1, 96);
        vecs[10] = mk(0, 0,   0,  0, 0,  0, 1, 96);
        for (int i = 0; i < 11; i++) begin
            MemWrite = vecs[i].we; MemRead = vecs[i].rd;
            DataAdr = vecs[i].adr; WriteData = vecs[i].wd;
            #4;
            check($sformatf("vec%0d_stall", i), 32'(Stall), 32'(vecs[i].stall));
            if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].rdata);
            check($sformatf("vec%0d_req", i), 32'(mem.mem_req), 32'(vecs[i].req));
            if (vecs[i].req) check($sformatf("vec%0d_addr", i), mem.mem_addr, vecs[i].addr);
            @(negedge clk);
        end

        // Single store, memory acks two cycles after the request
        do_reset();
        ack_en = 1'b1; mem_lat = 2;
        MemWrite = 1'b1; DataAdr = 32'd100; WriteData = 32'd25;
        #4;
        check("st1_accept_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        MemWrite = 1'b0;
        #4;
        check("st1_req",   32'(mem.mem_req), 32'd1);
        check("st1_we",    32'(mem.mem_we),  32'd1);
        check("st1_addr",  mem.mem_addr,     32'd100);
        check("st1_wdata", mem.mem_wdata,    32'd25);
        @(negedge clk);
        wait_empty("st1_empty");
        check("st1_mem_word", rd_mem(25), 32'd25);

        // Full FIFO: fifth store stalls, through the ack cycle, accepted right after
        do_reset();
        ack_en = 1'b0; mem_lat = 0;
        for (int i = 0; i < 4; i++) begin
            MemWrite = 1'b1; DataAdr = 32'(4 * i); WriteData = 32'(1000 + 4 * i);
            #4;
            check($sformatf("full_st%0d_stall", i), 32'(Stall), 32'd0);
            @(negedge clk);
        end
        DataAdr = 32'd16; WriteData = 32'd1016;
        for (int i = 0; i < 3; i++) begin
            #4;
            check($sformatf("full_wait%0d_stall", i), 32'(Stall), 32'd1);
            @(negedge clk);
        end
        ack_en = 1'b1;
        #4;
        check("full_pre_ack_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        ack_en = 1'b0;
        #4;
        check("full_ack_cycle_ack", 32'(mem.mem_ack), 32'd1);
        check("full_ack_cycle_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        #4;
        check("full_after_ack_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        DataAdr = 32'd20; WriteData = 32'd1020;
        #4;
        check("full_again_stall", 32'(Stall), 32'd1);
        @(negedge clk);
        MemWrite = 1'b0; ack_en = 1'b1;
        wait_empty("full_drain_empty");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("full_mem_word%0d", i), rd_mem(i), 32'(1000 + 4 * i));
        end

        // Load miss arriving while a buffered store is being written
        do_reset();
        ack_en = 1'b1; mem_lat = 1;
        mem_model[50] = 32'h1234;
        MemWrite = 1'b1; DataAdr = 32'd0; WriteData = 32'd5;
        #4;
        check("miss_store_stall", 32'(Stall), 32'd0);
        @(negedge clk);
        run_load(32'd200, 32'h1234, 5, "miss_behind_wr");
        check("miss_wr_landed", rd_mem(0), 32'd5);

        // Reset during a write abandons it and drops the buffered store
        do_reset();
        ack_en = 1'b0; mem_lat = 0;
        MemWrite = 1'b1; DataAdr = 32'd300; WriteData = 32'd77;
        @(negedge clk);
        MemWrite = 1'b0;
        #4;
        check("rstwr_req_before", 32'(mem.mem_req), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("rstwr_req_after",   32'(mem.mem_req), 32'd0);
        check("rstwr_empty_after", 32'(Empty),       32'd1);
        @(negedge clk);
        ack_en = 1'b1;
        run_load(32'd300, 32'd0, 2, "rstwr_lost_load");

        // Random traffic against architectural memory and FIFO occupancy model
        do_reset();
        q.delete();
        arch = mem_model;
        ack_en = 1'b1;
        for (int op = 0; op < 250; op++) begin
            int          kind;
            int          cyc;
            bit          done;
            bit          hit;
            bit          push;
            logic [29:0] w;
            logic [31:0] hv;
            kind = int'($urandom_range(0, 2));
            w = 30'($urandom_range(0, 7));
            if (op % 25 == 0) mem_lat = int'($urandom_range(0, 3));
            MemWrite = (kind == 1); MemRead = (kind == 2);
            DataAdr = {w, 2'($urandom)}; WriteData = $urandom;
            done = 1'b0; cyc = 0;
            while (!done) begin
                #4;
                hit = 1'b0; hv = '0; push = 1'b0;
                foreach (q[i]) begin
                    if (q[i].word == w) begin hit = 1'b1; hv = q[i].data; end
                end
                if (MemWrite) begin
                    check("rand_store_stall", 32'(Stall), 32'(q.size() == DEPTH));
                    if (q.size() < DEPTH) begin push = 1'b1; done = 1'b1; end
                end else if (MemRead) begin
                    if (hit) begin
                        check("rand_hit_stall", 32'(Stall), 32'd0);
                        check("rand_hit_rdata", ReadData, hv);
                        done = 1'b1;
                    end else if (!Stall) begin
                        check("rand_miss_rdata", ReadData, rd_arch(int'(w)));
                        done = 1'b1;
                    end
                end else begin
                    check("rand_idle_stall", 32'(Stall), 32'd0);
                    done = 1'b1;
                end
                if (q.size() != 0) check("rand_not_empty", 32'(Empty), 32'd0);
                if (mem.mem_ack && mem.mem_we) begin
                    if (q.size() != 0) begin
                        check("rand_drain_addr",  mem.mem_addr,  {q[0].word, 2'b00});
                        check("rand_drain_wdata", mem.mem_wdata, q[0].data);
                        void'(q.pop_front());
                    end else begin
                        check("rand_unexpected_write", 32'(mem.mem_we), 32'd0);
                    end
                end
                if (push) begin
                    ent_t e;
                    e.word = w; e.data = WriteData;
                    q.push_back(e);
                    arch[int'(w)] = WriteData;
                end
                cyc++;
                if (!done && cyc > 60) begin
                    check("rand_op_timeout", 32'(Stall), 32'd0);
                    done = 1'b1;
                end
                @(negedge clk);
            end
        end
        MemWrite = 1'b0; MemRead = 1'b0;
        wait_empty("rand_final_empty");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rand_mem_word%0d", i), rd_mem(i), rd_arch(i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
